// File: rtl/calc_pkg.sv
// Shared types and 7-segment constants for the calculator result display.
// Segment codes are gfedcba, active-low.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } calc_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble pre-shift correction: any nibble >= 5 gets +3.
    function automatic logic [11:0] dabble_adj(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/calc_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern (gfedcba), with a blank override.
module calc_seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        if (!blank) begin
            seg_n = seg7_code(bcd);
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Result display: captures an add/sub result, converts it to sign + 3 BCD digits by
// double-dabble, and scans a 4-digit 7-seg display. Optional macro: LEADING_ZERO_BLANK_EN.
//
// state    | meaning
// ST_IDLE  | ready for a new result (res_ready=1)
// ST_LOAD  | sign/magnitude from the captured word, BCD cleared
// ST_SHIFT | one double-dabble step per cycle, DATA_W cycles
// ST_DONE  | publish digits, sign and overflow to the display regs
module calc_result_display
    import calc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] res_in,
    input  logic              res_signed,
    input  logic              ovf_in,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              busy,
    output logic [3:0]        an_n,
    output logic [6:0]        seg_n,
    output logic              dp_n
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int REF_W = $clog2(REFRESH_DIV);

    calc_state_e       state_q, state_d;
    logic              res_ready_q, res_ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] cap_res_q, cap_res_d;
    logic              cap_signed_q, cap_signed_d;
    logic              cap_ovf_q, cap_ovf_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic [11:0]       disp_bcd_q, disp_bcd_d;
    logic              disp_neg_q, disp_neg_d;
    logic              disp_ovf_q, disp_ovf_d;

    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [3:0]        an_n_q, an_n_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;

    logic [3:0]        sel_bcd;
    logic              sel_blank;
    logic [6:0]        dec_seg_n;
    logic              blank_hund;
    logic              blank_tens;

    always_comb begin
        state_d      = state_q;
        cap_res_d    = cap_res_q;
        cap_signed_d = cap_signed_q;
        cap_ovf_d    = cap_ovf_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        neg_d        = neg_q;
        bit_cnt_d    = bit_cnt_q;
        disp_bcd_d   = disp_bcd_q;
        disp_neg_d   = disp_neg_q;
        disp_ovf_d   = disp_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (res_valid && res_ready_q) begin
                    cap_res_d    = res_in;
                    cap_signed_d = res_signed;
                    cap_ovf_d    = ovf_in;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The negated most-negative value is exact when read back as unsigned.
                neg_d     = cap_signed_q & cap_res_q[DATA_W-1];
                mag_d     = neg_d ? (~cap_res_q + 1'b1) : cap_res_q;
                bcd_d     = '0;
                bit_cnt_d = CNT_W'(DATA_W - 1);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = 12'({dabble_adj(bcd_q), mag_q[DATA_W-1]});
                mag_d = mag_q << 1;
                if (bit_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                disp_bcd_d = bcd_q;
                disp_neg_d = neg_q;
                disp_ovf_d = cap_ovf_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        res_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_hund = (disp_bcd_q[11:8] == 4'd0);
    assign blank_tens = (disp_bcd_q[11:8] == 4'd0) && (disp_bcd_q[7:4] == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    always_comb begin
        ref_cnt_d  = ref_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d  = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end

        sel_bcd   = 4'd0;
        sel_blank = 1'b1;
        case (scan_idx_q)
            2'd0: begin
                sel_bcd   = disp_bcd_q[3:0];
                sel_blank = 1'b0;
            end
            2'd1: begin
                sel_bcd   = disp_bcd_q[7:4];
                sel_blank = blank_tens;
            end
            2'd2: begin
                sel_bcd   = disp_bcd_q[11:8];
                sel_blank = blank_hund;
            end
            default: begin
                sel_bcd   = 4'd0;
                sel_blank = 1'b1;
            end
        endcase
    end

    calc_seg7_decoder u_seg7 (
        .bcd   (sel_bcd),
        .blank (sel_blank),
        .seg_n (dec_seg_n)
    );

    // Outputs are registered together so a slot never mixes old and new segments.
    always_comb begin
        an_n_d  = ~(4'b0001 << scan_idx_q);
        seg_n_d = dec_seg_n;
        if (scan_idx_q == 2'd3 && disp_neg_q) begin
            seg_n_d = SEG_MINUS;
        end
        dp_n_d = !(scan_idx_q == 2'd0 && disp_ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            res_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            cap_res_q    <= '0;
            cap_signed_q <= 1'b0;
            cap_ovf_q    <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            neg_q        <= 1'b0;
            bit_cnt_q    <= '0;
            disp_bcd_q   <= '0;
            disp_neg_q   <= 1'b0;
            disp_ovf_q   <= 1'b0;
            ref_cnt_q    <= '0;
            scan_idx_q   <= 2'd0;
            an_n_q       <= 4'b1111;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            res_ready_q  <= res_ready_d;
            busy_q       <= busy_d;
            cap_res_q    <= cap_res_d;
            cap_signed_q <= cap_signed_d;
            cap_ovf_q    <= cap_ovf_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            neg_q        <= neg_d;
            bit_cnt_q    <= bit_cnt_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_neg_q   <= disp_neg_d;
            disp_ovf_q   <= disp_ovf_d;
            ref_cnt_q    <= ref_cnt_d;
            scan_idx_q   <= scan_idx_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign res_ready = res_ready_q;
    assign busy      = busy_q;
    assign an_n      = an_n_q;
    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench for calc_result_display (DATA_W=8, REFRESH_DIV=4): directed table,
// busy/reset corner sequences, and random results against an arithmetic reference model.
module tb_calc_result_display;

    localparam int DW = 8;
    localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SBLANK = 7'h7F;
    localparam logic [6:0] SMINUS = 7'b0111111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] res_in = '0;
    logic          res_signed = 1'b0;
    logic          ovf_in = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic          busy;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] r;
        bit         s;
        bit         o;
        int         h;
        int         t;
        int         u;
        bit         neg;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    calc_result_display #(.DATA_W(DW), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_in     (res_in),
        .res_signed (res_signed),
        .ovf_in     (ovf_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return SBLANK;
        endcase
    endfunction

    // Reference: interpret the word as an integer, then split the magnitude into decimal digits.
    task automatic model(input logic [7:0] r, input bit s, output int h, output int t,
                         output int u, output bit neg);
        int v;
        int mag;
        v = int'(r);
        if (s && r[7]) v = v - 256;
        neg = (v < 0);
        mag = neg ? -v : v;
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
    endtask

    function automatic logic [7:0] exp_out(input int idx, input int h, input int t, input int u,
                                           input bit neg, input bit ovf);
        logic [6:0] s;
        logic       dp;
        dp = 1'b1;
        case (idx)
            0: begin
                s  = seg_of(u);
                dp = !ovf;
            end
            1: s = (LZB && h == 0 && t == 0) ? SBLANK : seg_of(t);
            2: s = (LZB && h == 0) ? SBLANK : seg_of(h);
            default: s = neg ? SMINUS : SBLANK;
        endcase
        return {dp, s};
    endfunction

    // One full scan frame: every slot must carry the expected pattern, each digit lit RD cycles.
    task automatic check_scan(input string name, input int h, input int t, input int u,
                              input bit neg, input bit ovf);
        int         cnt [4];
        int         idx;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 4 * RD; k++) begin
            @(negedge clk);
            case (an_n)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            chk({name, "_an_onehot"}, 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                e = exp_out(idx, h, t, u, neg, ovf);
                chk($sformatf("%s_seg_d%0d", name, idx), 32'(seg_n), 32'(e[6:0]));
                chk($sformatf("%s_dp_d%0d", name, idx), 32'(dp_n), 32'(e[7]));
                cnt[idx]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_slot%0d_cycles", name, i), 32'(cnt[i]), 32'(RD));
        end
    endtask

    // Enter and leave at a falling edge. With intrude set, a different word is offered while busy.
    task automatic send(input logic [7:0] r, input bit s, input bit o, input bit intrude);
        int n;
        int nb;
        n = 0;
        while (res_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", 32'(res_ready), 32'd1);
        res_in     = r;
        res_signed = s;
        ovf_in     = o;
        res_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        res_in    = ~r;
        chk("ready_low_after_accept", 32'(res_ready), 32'd0);
        nb = 0;
        n  = 0;
        while (busy === 1'b1 && n < 50) begin
            nb++;
            if (intrude && nb <= 5) begin
                res_valid = 1'b1;
                res_in    = r ^ 8'h5A;
                ovf_in    = ~o;
                chk("ready_low_while_busy", 32'(res_ready), 32'd0);
            end else begin
                res_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        res_valid = 1'b0;
        chk("busy_cycles", 32'(nb), 32'(DW + 2));
        chk("ready_after_done", 32'(res_ready), 32'd1);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int h;
        int t;
        int u;
        bit neg;
        logic [7:0] r;
        bit s;
        bit o;

        vecs[0] = '{8'h05, 1'b0, 1'b0, 0, 0, 5, 1'b0};
        vecs[1] = '{8'hFD, 1'b1, 1'b1, 0, 0, 3, 1'b1};
        vecs[2] = '{8'h80, 1'b1, 1'b0, 1, 2, 8, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 2, 5, 5, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b0, 0, 0, 7, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 0, 0, 1, 1'b1};
        vecs[6] = '{8'h7F, 1'b1, 1'b0, 1, 2, 7, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an_n", 32'(an_n), 32'h0000000F);
        chk("rst_seg_n", 32'(seg_n), 32'h0000007F);
        chk("rst_dp_n", 32'(dp_n), 32'd1);
        chk("rst_ready", 32'(res_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(res_ready), 32'd1);
        chk("post_rst_an_n", 32'(an_n), 32'h0000000E);
        chk("post_rst_seg_n", 32'(seg_n), 32'(seg_of(0)));
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_scan("reset_zero", 0, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].r, vecs[i].s, vecs[i].o, 1'b0);
            check_scan($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].u,
                       vecs[i].neg, vecs[i].o);
        end

        // New word offered during the conversion must not replace the first one.
        send(8'h2A, 1'b0, 1'b0, 1'b1);
        check_scan("busy_ignored", 0, 4, 2, 1'b0, 1'b0);

        // Load a visible non-zero value, then abandon a second conversion with reset.
        send(8'h9C, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        res_in     = 8'hFF;
        res_signed = 1'b0;
        ovf_in     = 1'b1;
        res_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_shift_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_an_n", 32'(an_n), 32'h0000000F);
        chk("midrst_seg_n", 32'(seg_n), 32'h0000007F);
        chk("midrst_dp_n", 32'(dp_n), 32'd1);
        chk("midrst_ready", 32'(res_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        chk("midrst_idle_ready", 32'(res_ready), 32'd1);
        check_scan("after_midrst", 0, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            r = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            model(r, s, h, t, u, neg);
            send(r, s, o, 1'b0);
            check_scan($sformatf("rand%0d_%02h_s%0d", k, r, s), h, t, u, neg, o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
